sme_job_sequencer: RTL and testbench
====================================

// Module: sme_job_sequencer
// PURPOSE
//  Host-side controller for the string-matching engine (SME). Buffers one string and up to NUM_PAT patterns.
//  On start, replays string+pattern to the engine once per pattern, because the engine clears its string
//  after each valid. Captures each verdict as a result record and delivers it over a ready/valid port.
// PARAMETERS
//  STR_MAX   32  max string chars held (engine buffer depth)
//  PAT_MAX   8   max chars per pattern, including '^' / '$'
//  NUM_PAT   4   pattern slots
//  TIMEOUT   96  WAIT cycles before a verdict is forced as timeout
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  synchronous, active-high
//  str_wr         in   1  append str_char to string buffer (IDLE only)
//  str_char       in   8  string character
//  pat_wr         in   1  append pat_char to current pattern slot (IDLE only)
//  pat_char       in   8  pattern character
//  pat_last       in   1  with pat_wr: char closes current slot, slot index advances
//  clear          in   1  empty string and all pattern slots (IDLE only)
//  start          in   1  begin job (IDLE only)
//  busy           out  1  high in every state except IDLE
//  done           out  1  one-cycle pulse on the cycle after the last result is accepted
//  err            out  1  sticky overflow/empty error; cleared by clear or reset
//  eng_chardata   out  8  engine char bus
//  eng_isstring   out  1  engine string strobe
//  eng_ispattern  out  1  engine pattern strobe
//  eng_valid      in   1  engine verdict valid (level, held until next string)
//  eng_match      in   1  engine match flag
//  eng_index      in   5  engine match index
//  res_valid      out  1  result record available
//  res_ready      in   1  consumer accepts the record when res_valid&&res_ready
//  res_id         out  2  pattern slot of the record (log2 NUM_PAT)
//  res_match      out  1  captured eng_match (0 on timeout)
//  res_index      out  5  captured eng_index (0 on no-match or timeout)
//  res_timeout    out  1  record forced by the watchdog
// BEHAVIOUR
//  Reset: all outputs 0; str_len=0, pat_cnt=0, all pat_len=0; state IDLE. Reset mid-job aborts in the same cycle,
//   no done pulse.
//  Loading (IDLE): str_wr ignored when str_len==STR_MAX and sets err. pat_wr into a slot already holding PAT_MAX
//   chars is dropped and sets err. pat_wr when pat_cnt==NUM_PAT is dropped and sets err.
//   pat_last increments pat_cnt. Same-cycle str_wr and pat_wr are both accepted. clear has priority over writes.
//  start in IDLE with str_len==0 or pat_cnt==0: set err, pulse done next cycle, stay IDLE. start while busy: ignored.
//  FSM: IDLE -> SEND_STR -> SEND_PAT -> WAIT -> REPORT -> (SEND_STR for next slot | DONE) ; DONE -> IDLE.
//  SEND_STR: str_len cycles, eng_isstring=1, eng_chardata=str[i], i=0..str_len-1. The first char is on the cycle
//   after start.
//  SEND_PAT: pat_len[k] cycles, eng_ispattern=1, chars of slot k in order. The first cycle follows the last string
//   char with no gap.
//  WAIT: strobes 0, eng_chardata=0. Watchdog counts from 0. The first cycle with eng_valid=1 captures match/index
//   into the res_* registers.
//   Watchdog==TIMEOUT-1 without eng_valid forces res_match=0, res_index=0, res_timeout=1. Then -> REPORT.
//  REPORT: res_valid=1 and res_* are stable until the handshake. On res_valid&&res_ready: res_valid->0 next cycle.
//   k++; k==pat_cnt -> DONE else SEND_STR. No overlap: the engine is never driven while a record is pending.
//  DONE: done=1 for exactly one cycle, -> IDLE. Buffers are retained, so a repeated start reruns the same job.
//  eng_isstring and eng_ispattern are never high together. Strobes are registered, with no combinational path
//   from eng_* to eng_*.
//  Slot counter and watchdog never wrap within a job. res_id=k. Records are emitted in slot order 0..pat_cnt-1.
// TESTING
//  1 str "hello world", slot0 "wor", start -> 11 isstring cycles, 3 ispattern cycles; record id0 match=1 index=6;
//    done pulse.
//  2 slots "^wor","ld$","xyz",".o" -> 4 records in order, id0..3: (1,6),(1,9),(0,0),(1,3); string replayed 4 times.
//  3 res_ready held 0 for 20 cycles in REPORT -> res_* stable, eng strobes 0, no next SEND_STR until accept.
//  4 engine model never asserts valid -> after 96 WAIT cycles, record res_timeout=1 match=0 index=0; job continues.
//  5 33 str_wr, 9-char pattern, 5th pat_last -> err=1, str_len=32, overflow chars dropped; clear -> err=0.
//  6 reset asserted during SEND_PAT -> next cycle busy=0, strobes 0, res_valid=0, no done; start with empty
//    buffers -> err=1, done pulse.

Source files
------------

// File: rtl/sme_job_sequencer.sv
// Host-side job sequencer for the string-matching engine: buffers one string and a set of
// patterns, replays string+pattern per slot, and returns each verdict as a ready/valid record.
module sme_job_sequencer #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int NUM_PAT = 4,
  parameter int TIMEOUT = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       str_wr,
  input  logic [7:0]                 str_char,
  input  logic                       pat_wr,
  input  logic [7:0]                 pat_char,
  input  logic                       pat_last,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [7:0]                 eng_chardata,
  output logic                       eng_isstring,
  output logic                       eng_ispattern,
  input  logic                       eng_valid,
  input  logic                       eng_match,
  input  logic [$clog2(STR_MAX)-1:0] eng_index,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_PAT)-1:0] res_id,
  output logic                       res_match,
  output logic [$clog2(STR_MAX)-1:0] res_index,
  output logic                       res_timeout
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int PIW = $clog2(PAT_MAX);
  localparam int PCW = $clog2(NUM_PAT + 1);
  localparam int KW  = $clog2(NUM_PAT);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t         state;
  logic [7:0]     str_buf [STR_MAX];
  logic [7:0]     pat_buf [NUM_PAT][PAT_MAX];
  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len [NUM_PAT];
  logic [PCW-1:0] pat_cnt;
  logic [SIW-1:0] str_idx;
  logic [PIW-1:0] pat_idx;
  logic [KW-1:0]  slot;
  logic [WDW-1:0] wd;

  logic           load_ok;
  logic           str_full;
  logic           pat_full;
  logic           slot_full;
  logic [KW-1:0]  wr_slot;
  logic           str_we;
  logic           pat_we;
  logic           pat_close;
  logic           load_err;
  logic [SIW-1:0] str_idx_nxt;
  logic [PIW-1:0] pat_idx_nxt;
  logic           last_str;
  logic           last_pat;
  logic           last_slot;

  always_comb begin
    load_ok     = (state == S_IDLE) && !clear && !start;
    str_full    = (str_len == SLW'(STR_MAX));
    pat_full    = (pat_cnt == PCW'(NUM_PAT));
    wr_slot     = KW'(pat_cnt);
    // wr_slot aliases slot 0 once all slots are closed; pat_full masks that case
    slot_full   = pat_full || (pat_len[wr_slot] == PLW'(PAT_MAX));
    str_we      = load_ok && str_wr && !str_full;
    pat_we      = load_ok && pat_wr && !slot_full;
    pat_close   = load_ok && pat_wr && pat_last && !pat_full;
    load_err    = load_ok && ((str_wr && str_full) || (pat_wr && slot_full));
    str_idx_nxt = str_idx + SIW'(1);
    pat_idx_nxt = pat_idx + PIW'(1);
    last_str    = (SLW'(str_idx) == str_len - SLW'(1));
    last_pat    = (PLW'(pat_idx) == pat_len[slot] - PLW'(1));
    last_slot   = (PCW'(slot) + PCW'(1) == pat_cnt);
  end

  always_ff @(posedge clk) begin
    if (str_we) str_buf[str_len[SIW-1:0]] <= str_char;
    if (pat_we) pat_buf[wr_slot][pat_len[wr_slot][PIW-1:0]] <= pat_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      eng_chardata  <= '0;
      eng_isstring  <= 1'b0;
      eng_ispattern <= 1'b0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_timeout   <= 1'b0;
      str_len       <= '0;
      pat_cnt       <= '0;
      for (int unsigned i = 0; i < NUM_PAT; i++) pat_len[i] <= '0;
      str_idx       <= '0;
      pat_idx       <= '0;
      slot          <= '0;
      wd            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear) begin
            str_len <= '0;
            pat_cnt <= '0;
            for (int unsigned i = 0; i < NUM_PAT; i++) pat_len[i] <= '0;
            err     <= 1'b0;
          end else if (start) begin
            if (str_len == '0 || pat_cnt == '0) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              state        <= S_SEND_STR;
              busy         <= 1'b1;
              slot         <= '0;
              str_idx      <= '0;
              eng_isstring <= 1'b1;
              eng_chardata <= str_buf[0];
            end
          end else begin
            if (str_we)    str_len <= str_len + SLW'(1);
            if (pat_we)    pat_len[wr_slot] <= pat_len[wr_slot] + PLW'(1);
            if (pat_close) pat_cnt <= pat_cnt + PCW'(1);
            if (load_err)  err <= 1'b1;
          end
        end
        S_SEND_STR: begin
          if (last_str) begin
            state         <= S_SEND_PAT;
            eng_isstring  <= 1'b0;
            eng_ispattern <= 1'b1;
            pat_idx       <= '0;
            eng_chardata  <= pat_buf[slot][0];
          end else begin
            str_idx      <= str_idx_nxt;
            eng_chardata <= str_buf[str_idx_nxt];
          end
        end
        S_SEND_PAT: begin
          if (last_pat) begin
            state         <= S_WAIT;
            eng_ispattern <= 1'b0;
            eng_chardata  <= '0;
            wd            <= '0;
          end else begin
            pat_idx      <= pat_idx_nxt;
            eng_chardata <= pat_buf[slot][pat_idx_nxt];
          end
        end
        S_WAIT: begin
          if (eng_valid) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_id      <= slot;
            res_match   <= eng_match;
            res_index   <= eng_match ? eng_index : '0;
            res_timeout <= 1'b0;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_id      <= slot;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_slot) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_SEND_STR;
              slot         <= slot + KW'(1);
              str_idx      <= '0;
              eng_isstring <= 1'b1;
              eng_chardata <= str_buf[0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed bench for sme_job_sequencer with a behavioural string-matching engine responder.
module tb_sme_job_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       str_wr = 1'b0, pat_wr = 1'b0, pat_last = 1'b0, clear = 1'b0, start = 1'b0;
  logic [7:0] str_char = '0, pat_char = '0;
  logic       busy, done, err;
  logic [7:0] eng_chardata;
  logic       eng_isstring, eng_ispattern;
  logic       eng_valid, eng_match;
  logic [4:0] eng_index;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_id;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;

  int total = 0;
  int bad = 0;

  sme_job_sequencer #(.STR_MAX(32), .PAT_MAX(8), .NUM_PAT(4), .TIMEOUT(96)) dut (
    .clk(clk), .reset(reset),
    .str_wr(str_wr), .str_char(str_char),
    .pat_wr(pat_wr), .pat_char(pat_char), .pat_last(pat_last),
    .clear(clear), .start(start),
    .busy(busy), .done(done), .err(err),
    .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
    .eng_valid(eng_valid), .eng_match(eng_match), .eng_index(eng_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  // Engine: '^' = start of string or after a space, '$' = end or before a space, '.' = any char
  logic [7:0] e_str [64];
  logic [7:0] e_pat [16];
  int         e_slen, e_plen, e_lat;
  logic       e_prev_str, e_prev_pat;
  logic       eng_mute = 1'b0;

  function automatic logic [5:0] e_find();
    int first, last;
    logic anc_s, anc_e, ok;
    first = 0;
    last  = e_plen - 1;
    anc_s = (e_pat[0] == "^");
    anc_e = (e_pat[last[3:0]] == "$");
    if (anc_s) first = 1;
    if (anc_e) last = last - 1;
    for (int s = 0; s < e_slen; s++) begin
      ok = 1'b1;
      if (anc_s && s > 0 && e_str[s[5:0] - 6'd1] != " ") ok = 1'b0;
      for (int j = first; j <= last; j++) begin
        int p;
        p = s + j - first;
        if (p >= e_slen) ok = 1'b0;
        else if (e_pat[j[3:0]] != "." && e_pat[j[3:0]] != e_str[p[5:0]]) ok = 1'b0;
      end
      if (anc_e) begin
        int q;
        q = s + last - first + 1;
        if (q < e_slen && e_str[q[5:0]] != " ") ok = 1'b0;
      end
      if (ok) return {1'b1, s[4:0]};
    end
    return 6'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      eng_valid  <= 1'b0;
      eng_match  <= 1'b0;
      eng_index  <= '0;
      e_slen     <= 0;
      e_plen     <= 0;
      e_lat      <= 0;
      e_prev_str <= 1'b0;
      e_prev_pat <= 1'b0;
    end else begin
      if (eng_isstring) begin
        if (!e_prev_str) begin
          e_str[0]  <= eng_chardata;
          e_slen    <= 1;
          e_plen    <= 0;
          eng_valid <= 1'b0;
        end else if (e_slen < 64) begin
          e_str[e_slen[5:0]] <= eng_chardata;
          e_slen <= e_slen + 1;
        end
      end
      if (eng_ispattern && e_plen < 16) begin
        e_pat[e_plen[3:0]] <= eng_chardata;
        e_plen <= e_plen + 1;
      end
      if (e_prev_pat && !eng_ispattern) e_lat <= 3;
      else if (e_lat > 0) begin
        e_lat <= e_lat - 1;
        if (e_lat == 1 && !eng_mute) begin
          eng_valid <= 1'b1;
          {eng_match, eng_index} <= e_find();
        end
      end
      e_prev_str <= eng_isstring;
      e_prev_pat <= eng_ispattern;
    end
  end

  // Free-running strobe monitors; tests take differences between snapshots
  int str_cyc = 0, pat_cyc = 0, both_cyc = 0, wait_cyc = 0;
  always @(negedge clk) begin
    if (eng_isstring) str_cyc <= str_cyc + 1;
    if (eng_ispattern) pat_cyc <= pat_cyc + 1;
    if (eng_isstring && eng_ispattern) both_cyc <= both_cyc + 1;
    if (busy && !eng_isstring && !eng_ispattern && !res_valid && !done) wait_cyc <= wait_cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      str_wr = 1'b1;
      str_char = s[i];
      tick();
    end
    str_wr = 1'b0;
  endtask

  task automatic put_pat(input string s);
    for (int i = 0; i < s.len(); i++) begin
      pat_wr = 1'b1;
      pat_char = s[i];
      pat_last = (i == s.len() - 1);
      tick();
    end
    pat_wr = 1'b0;
    pat_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns {found, id, match, index, timeout} and accepts the record
  task automatic take(input int limit, output logic [9:0] rec);
    logic found;
    found = 1'b0;
    rec = '0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
        rec = {1'b1, res_id, res_match, res_index, res_timeout};
      end
    end
    if (found) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, err, eng_chardata, eng_isstring, eng_ispattern, res_valid, res_id,
         res_match, res_index, res_timeout} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, done, err, eng_chardata, eng_isstring,
               eng_ispattern, res_valid, res_id, res_match, res_index, res_timeout});
    end
    tick();
  endtask

  task automatic test_single();
    logic [9:0] rec;
    logic seen;
    int s0, p0;
    do_clear();
    put_str("hello world");
    put_pat("wor");
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err); end
    s0 = str_cyc; p0 = pat_cyc;
    do_start();
    take(300, rec);
    total++;
    if (rec !== {1'b1, 2'd0, 1'b1, 5'd6, 1'b0}) begin
      bad++; $display("FAIL single_record got=%b exp=%b", rec, {1'b1, 2'd0, 1'b1, 5'd6, 1'b0});
    end
    wait_done(20, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", seen); end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL single_done_width got=%b exp=00", {done, busy}); end
    total++;
    if (str_cyc - s0 != 11) begin bad++; $display("FAIL single_str_cycles got=%0d exp=11", str_cyc - s0); end
    total++;
    if (pat_cyc - p0 != 3) begin bad++; $display("FAIL single_pat_cycles got=%0d exp=3", pat_cyc - p0); end
    tick();
  endtask

  logic [4:0] exp_ix [4] = '{5'd6, 5'd9, 5'd0, 5'd3};
  logic       exp_m  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  task automatic test_multi();
    logic [9:0] rec;
    logic seen;
    int s0, p0, b0;
    do_clear();
    put_str("hello world");
    put_pat("^wor");
    put_pat("ld$");
    put_pat("xyz");
    put_pat(".o");
    s0 = str_cyc; p0 = pat_cyc; b0 = both_cyc;
    do_start();
    for (int k = 0; k < 4; k++) begin
      take(300, rec);
      total++;
      if (rec !== {1'b1, k[1:0], exp_m[k], exp_ix[k], 1'b0}) begin
        bad++; $display("FAIL multi_record%0d got=%b exp=%b", k, rec, {1'b1, k[1:0], exp_m[k], exp_ix[k], 1'b0});
      end
    end
    wait_done(20, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL multi_done got=%b exp=1", seen); end
    total++;
    if (str_cyc - s0 != 44) begin bad++; $display("FAIL multi_str_cycles got=%0d exp=44", str_cyc - s0); end
    total++;
    if (pat_cyc - p0 != 12) begin bad++; $display("FAIL multi_pat_cycles got=%0d exp=12", pat_cyc - p0); end
    total++;
    if (both_cyc != b0) begin bad++; $display("FAIL multi_strobe_overlap got=%0d exp=0", both_cyc - b0); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [9:0] rec;
    logic [8:0] v0;
    logic seen, found;
    int bad_hold, s0;
    s0 = str_cyc;
    do_start();
    found = 1'b0;
    v0 = '0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (res_valid) begin found = 1'b1; v0 = {res_id, res_match, res_index, res_timeout}; end
    end
    total++;
    if ({found, v0} !== {1'b1, 2'd0, 1'b1, 5'd6, 1'b0}) begin
      bad++; $display("FAIL bp_first_record got=%b exp=%b", {found, v0}, {1'b1, 2'd0, 1'b1, 5'd6, 1'b0});
    end
    bad_hold = 0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid || {res_id, res_match, res_index, res_timeout} !== v0 || eng_isstring || eng_ispattern)
        bad_hold++;
    end
    start = 1'b0;
    total++;
    if (bad_hold != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad_hold); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", res_valid); end
    for (int k = 1; k < 4; k++) begin
      take(300, rec);
      total++;
      if (rec !== {1'b1, k[1:0], exp_m[k], exp_ix[k], 1'b0}) begin
        bad++; $display("FAIL bp_record%0d got=%b exp=%b", k, rec, {1'b1, k[1:0], exp_m[k], exp_ix[k], 1'b0});
      end
    end
    wait_done(20, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", seen); end
    total++;
    if (str_cyc - s0 != 44) begin bad++; $display("FAIL bp_str_cycles got=%0d exp=44", str_cyc - s0); end
    tick();
    tick();
    total++;
    if ({busy, res_valid} !== 2'b00) begin bad++; $display("FAIL bp_idle got=%b exp=00", {busy, res_valid}); end
  endtask

  task automatic test_timeout();
    logic [9:0] rec;
    logic seen;
    int w0;
    do_clear();
    put_str("abc");
    put_pat("b");
    put_pat("c");
    eng_mute = 1'b1;
    w0 = wait_cyc;
    do_start();
    take(400, rec);
    total++;
    if (rec !== {1'b1, 2'd0, 1'b0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL timeout_record got=%b exp=%b", rec, {1'b1, 2'd0, 1'b0, 5'd0, 1'b1});
    end
    total++;
    if (wait_cyc - w0 != 96) begin bad++; $display("FAIL timeout_wait_cycles got=%0d exp=96", wait_cyc - w0); end
    eng_mute = 1'b0;
    take(400, rec);
    total++;
    if (rec !== {1'b1, 2'd1, 1'b1, 5'd2, 1'b0}) begin
      bad++; $display("FAIL timeout_next_record got=%b exp=%b", rec, {1'b1, 2'd1, 1'b1, 5'd2, 1'b0});
    end
    wait_done(20, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL timeout_done got=%b exp=1", seen); end
    tick();
  endtask

  task automatic test_overflow();
    logic [9:0] rec;
    logic seen;
    int s0, p0;
    do_clear();
    put_pat("a"); put_pat("b"); put_pat("c"); put_pat("d");
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_four_slots_err got=%b exp=0", err); end
    put_pat("e");
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL ovf_fifth_slot_err got=%b exp=1", err); end
    do_clear();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_clear_err got=%b exp=0", err); end
    put_str("abcdefghijklmnopqrstuvwxyzABCDEF");
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_str_full_err got=%b exp=0", err); end
    put_str("Z");
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL ovf_str_extra_err got=%b exp=1", err); end
    put_pat("uvwxyzABQ");
    s0 = str_cyc; p0 = pat_cyc;
    do_start();
    take(300, rec);
    total++;
    if (rec !== {1'b1, 2'd0, 1'b1, 5'd20, 1'b0}) begin
      bad++; $display("FAIL ovf_record got=%b exp=%b", rec, {1'b1, 2'd0, 1'b1, 5'd20, 1'b0});
    end
    wait_done(20, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", seen); end
    total++;
    if (str_cyc - s0 != 32) begin bad++; $display("FAIL ovf_str_cycles got=%0d exp=32", str_cyc - s0); end
    total++;
    if (pat_cyc - p0 != 8) begin bad++; $display("FAIL ovf_pat_cycles got=%0d exp=8", pat_cyc - p0); end
    tick();
    do_clear();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_final_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_midjob();
    logic seen;
    int noisy;
    do_clear();
    put_str("hello world");
    put_pat("wor");
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (eng_ispattern) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL rst_reach_send_pat got=%b exp=1", seen); end
    reset = 1'b1;
    tick();
    total++;
    if ({busy, eng_isstring, eng_ispattern, res_valid, done, err} !== 6'd0) begin
      bad++; $display("FAIL rst_abort got=%b exp=000000", {busy, eng_isstring, eng_ispattern, res_valid, done, err});
    end
    reset = 1'b0;
    noisy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || res_valid || busy || eng_isstring || eng_ispattern) noisy++;
    end
    total++;
    if (noisy != 0) begin bad++; $display("FAIL rst_quiet got=%0d active cycles exp=0", noisy); end
    tick();
    do_start();
    total++;
    if ({err, done, busy} !== 3'b110) begin bad++; $display("FAIL rst_empty_start got=%b exp=110", {err, done, busy}); end
    tick();
    total++;
    if ({err, done, busy} !== 3'b100) begin bad++; $display("FAIL rst_empty_after got=%b exp=100", {err, done, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_pressure();
    test_timeout();
    test_overflow();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
